// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N up/down counter family: direction
// encodings and parameter-legality helpers evaluated at elaboration.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A modulus is legal when 2 <= MODULUS <= 2^WIDTH and WIDTH is 1..16.
  function automatic bit modulus_legal(input int width, input int modulus);
    if (width < 1 || width > 16) return 1'b0;
    if (modulus < 2) return 1'b0;
    if ($clog2(modulus) > width) return 1'b0;
    return 1'b1;
  endfunction

  // The natural binary roll-over only matches the modulus when it fills
  // the whole WIDTH-bit range; otherwise wrap must be forced explicitly.
  function automatic bit needs_wrap(input int width, input int modulus);
    return modulus < (1 << width);
  endfunction

endpackage

// File: rtl/counter_bit_cell.sv
// Single counter bit: negative-edge toggle flop with asynchronous clear and
// a synchronous load that takes priority over the toggle.
module counter_bit_cell (
  input  logic clk_i,
  input  logic clr_i,
  input  logic tog_i,
  input  logic ld_i,
  input  logic ld_val_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // Next state: load beats toggle, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (tog_i) begin
      q_d = ~q_q;
    end
  end

  // State register on the falling edge, cleared asynchronously.
  always_ff @(negedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised modulo-N up/down counter built from WIDTH toggle cells.
// Priority: clr (async) > pre > load > en count > hold. Loads (preset,
// clamped parallel load, forced wrap) go through the cells' load path;
// ordinary counting uses a synchronous T-chain.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             pre,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL  = '0;
  localparam bit               NEED_WRAP = needs_wrap(WIDTH, MODULUS);

  if (!modulus_legal(WIDTH, MODULUS)) begin : g_param_check
    $error("updown_counter_mod: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end

  logic             at_wrap;
  logic             ld_all;
  logic [WIDTH-1:0] ld_val;
  logic             tog_en;
  logic [WIDTH-1:0] chain;

  assign at_wrap = (up == DIR_UP) ? (q == MAX_VAL) : (q == ZERO_VAL);
  assign tc      = en & at_wrap;
  assign q_bar   = ~q;

  // Priority mux: decide between a full-word load and T-chain counting.
  always_comb begin
    ld_all = 1'b0;
    ld_val = ZERO_VAL;
    tog_en = 1'b0;
    if (pre) begin
      ld_all = 1'b1;
      ld_val = MAX_VAL;
    end else if (load) begin
      ld_all = 1'b1;
      ld_val = (d > MAX_VAL) ? MAX_VAL : d;
    end else if (en) begin
      if (NEED_WRAP && at_wrap) begin
        ld_all = 1'b1;
        ld_val = (up == DIR_UP) ? ZERO_VAL : MAX_VAL;
      end else begin
        tog_en = 1'b1;
      end
    end
  end

  // Toggle chain: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic run;
    run   = 1'b1;
    chain = '0;
    for (int i = 0; i < WIDTH; i++) begin
      chain[i] = run;
      run      = run & ((up == DIR_UP) ? q[i] : ~q[i]);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    counter_bit_cell u_cell (
      .clk_i   (clk),
      .clr_i   (clr),
      .tog_i   (tog_en & chain[i]),
      .ld_i    (ld_all),
      .ld_val_i(ld_val[i]),
      .q_o     (q[i])
    );
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: a modulo-16 instance, and two modulo-10
// instances cascaded through tc. Directed scenarios plus randomized
// stimulus compared against an arithmetic reference model.
module tb_updown_counter_mod;

  int total = 0;
  int bad   = 0;

  logic clk;

  // Modulo-16 instance (a)
  logic       clr_a, en_a, up_a, load_a, pre_a;
  logic [3:0] d_a, q_a, qb_a;
  logic       tc_a;

  // Modulo-10 stage 0 (b) and stage 1 (c), cascaded
  logic       clr_b, en_b, up_b, load_b, pre_b;
  logic [3:0] d_b, q_b, qb_b;
  logic       tc_b;
  logic       load_c, pre_c;
  logic [3:0] d_c, q_c, qb_c;
  logic       tc_c;

  updown_counter_mod #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .clk(clk), .clr(clr_a), .en(en_a), .up(up_a), .load(load_a), .pre(pre_a),
    .d(d_a), .q(q_a), .q_bar(qb_a), .tc(tc_a)
  );

  updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_m10_s0 (
    .clk(clk), .clr(clr_b), .en(en_b), .up(up_b), .load(load_b), .pre(pre_b),
    .d(d_b), .q(q_b), .q_bar(qb_b), .tc(tc_b)
  );

  updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_m10_s1 (
    .clk(clk), .clr(clr_b), .en(tc_b), .up(up_b), .load(load_c), .pre(pre_c),
    .d(d_c), .q(q_c), .q_bar(qb_c), .tc(tc_c)
  );

  // Clock: falling edges at 5, 15, 25, ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Reference model: next count from the operation rules, plain arithmetic.
  function automatic int model_next(input int cur, input bit en, input bit up,
                                    input bit load, input bit pre, input int d,
                                    input int modulus);
    if (pre) return modulus - 1;
    if (load) return (d < modulus) ? d : modulus - 1;
    if (en) return up ? (cur + 1) % modulus : (cur + modulus - 1) % modulus;
    return cur;
  endfunction

  // Advance to just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_b_value(input logic [3:0] v);
    load_b = 1'b1; d_b = v;
    tick();
    load_b = 1'b0;
  endtask

  task automatic test_reset();
    clr_a = 1'b1; en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; pre_a = 1'b0; d_a = '0;
    #3;
    total++;
    if (q_a !== 4'd0 || qb_a !== 4'hF) begin
      bad++; $display("FAIL reset_initial q=%0d q_bar=%h exp q=0 q_bar=f", q_a, qb_a);
    end
    tick();
    clr_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
    repeat (9) tick();
    total++;
    if (q_a !== 4'd9) begin
      bad++; $display("FAIL reset_precount q=%0d exp=9", q_a);
    end
    // Clear between edges with a pending count and load
    #2; load_a = 1'b1; d_a = 4'd3; clr_a = 1'b1;
    #1;
    total++;
    if (q_a !== 4'd0 || qb_a !== 4'hF) begin
      bad++; $display("FAIL reset_async q=%0d q_bar=%h exp q=0 q_bar=f", q_a, qb_a);
    end
    up_a = 1'b0;
    #1;
    total++;
    if (tc_a !== 1'b1) begin
      bad++; $display("FAIL reset_tc_down tc=%b exp=1", tc_a);
    end
    up_a = 1'b1; load_a = 1'b0;
    #1;
    clr_a = 1'b0;
    tick();
    total++;
    if (q_a !== 4'd1) begin
      bad++; $display("FAIL reset_release q=%0d exp=1", q_a);
    end
    en_a = 1'b0;
  endtask

  task automatic test_up_wrap();
    en_b = 1'b0; up_b = 1'b1;
    load_b_value(4'd8);
    en_b = 1'b1; up_b = 1'b1;
    #1;
    total++;
    if (q_b !== 4'd8 || tc_b !== 1'b0) begin
      bad++; $display("FAIL up_wrap_start q=%0d tc=%b exp q=8 tc=0", q_b, tc_b);
    end
    tick();
    total++;
    if (q_b !== 4'd9 || tc_b !== 1'b1) begin
      bad++; $display("FAIL up_wrap_top q=%0d tc=%b exp q=9 tc=1", q_b, tc_b);
    end
    tick();
    total++;
    if (q_b !== 4'd0 || tc_b !== 1'b0) begin
      bad++; $display("FAIL up_wrap_zero q=%0d tc=%b exp q=0 tc=0", q_b, tc_b);
    end
  endtask

  task automatic test_down_wrap();
    int exp_seq[3] = '{9, 8, 7};
    up_b = 1'b0; en_b = 1'b1;
    #1;
    total++;
    if (q_b !== 4'd0 || tc_b !== 1'b1) begin
      bad++; $display("FAIL down_wrap_tc q=%0d tc=%b exp q=0 tc=1", q_b, tc_b);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (q_b !== 4'(exp_seq[i]) || qb_b !== ~4'(exp_seq[i])) begin
        bad++; $display("FAIL down_wrap_step%0d q=%0d q_bar=%h exp=%0d", i, q_b, qb_b, exp_seq[i]);
      end
    end
    en_b = 1'b0;
  endtask

  task automatic test_load_clamp();
    en_b = 1'b0;
    load_b_value(4'd6);
    total++;
    if (q_b !== 4'd6) begin
      bad++; $display("FAIL load_6 q=%0d exp=6", q_b);
    end
    load_b_value(4'd13);
    total++;
    if (q_b !== 4'd9) begin
      bad++; $display("FAIL load_clamp13 q=%0d exp=9", q_b);
    end
    load_b_value(4'd3);
    total++;
    if (q_b !== 4'd3) begin
      bad++; $display("FAIL load_3 q=%0d exp=3", q_b);
    end
    pre_b = 1'b1; load_b = 1'b1; d_b = 4'd2;
    tick();
    pre_b = 1'b0; load_b = 1'b0;
    total++;
    if (q_b !== 4'd9) begin
      bad++; $display("FAIL pre_over_load q=%0d exp=9", q_b);
    end
  endtask

  task automatic test_enable_direction();
    int exp_seq[3] = '{6, 5, 6};
    bit dir_seq[3] = '{1'b1, 1'b0, 1'b1};
    en_b = 1'b0;
    load_b_value(4'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (q_b !== 4'd5) begin
        bad++; $display("FAIL hold_%0d q=%0d exp=5", i, q_b);
      end
    end
    en_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_b = dir_seq[i];
      tick();
      total++;
      if (q_b !== 4'(exp_seq[i])) begin
        bad++; $display("FAIL dir_step%0d q=%0d exp=%0d", i, q_b, exp_seq[i]);
      end
    end
    en_b = 1'b0;
  endtask

  task automatic test_cascade();
    en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; pre_b = 1'b0; load_c = 1'b0; pre_c = 1'b0;
    clr_b = 1'b1;
    #2;
    clr_b = 1'b0;
    tick();
    en_b = 1'b1;
    for (int n = 0; n < 100; n++) begin
      #1;
      total++;
      if (q_c !== 4'(n / 10) || q_b !== 4'(n % 10) || tc_c !== (n == 99)) begin
        bad++;
        $display("FAIL cascade_n%0d got=%0d%0d tc1=%b exp=%0d tc1=%b",
                 n, q_c, q_b, tc_c, n, (n == 99));
      end
      tick();
    end
    total++;
    if (q_c !== 4'd0 || q_b !== 4'd0) begin
      bad++; $display("FAIL cascade_return got=%0d%0d exp=00", q_c, q_b);
    end
    en_b = 1'b0;
  endtask

  task automatic test_random();
    int m16, m10;
    clr_a = 1'b1; clr_b = 1'b1;
    #2;
    clr_a = 1'b0; clr_b = 1'b0;
    tick();
    m16 = 0; m10 = 0;
    for (int i = 0; i < 300; i++) begin
      en_a = 1'($urandom_range(0, 3) != 0); up_a = 1'($urandom_range(0, 1));
      load_a = 1'($urandom_range(0, 7) == 0); pre_a = 1'($urandom_range(0, 15) == 0);
      d_a = 4'($urandom_range(0, 15));
      en_b = 1'($urandom_range(0, 3) != 0); up_b = 1'($urandom_range(0, 1));
      load_b = 1'($urandom_range(0, 7) == 0); pre_b = 1'($urandom_range(0, 15) == 0);
      d_b = 4'($urandom_range(0, 15));
      #1;
      total++;
      if (tc_a !== (en_a && (up_a ? m16 == 15 : m16 == 0)) ||
          tc_b !== (en_b && (up_b ? m10 == 9 : m10 == 0))) begin
        bad++; $display("FAIL rand_tc_%0d tc16=%b tc10=%b model q16=%0d q10=%0d", i, tc_a, tc_b, m16, m10);
      end
      m16 = model_next(m16, en_a, up_a, load_a, pre_a, int'(d_a), 16);
      m10 = model_next(m10, en_b, up_b, load_b, pre_b, int'(d_b), 10);
      tick();
      total++;
      if (q_a !== 4'(m16) || qb_a !== ~4'(m16) || q_b !== 4'(m10) || qb_b !== ~4'(m10)) begin
        bad++; $display("FAIL rand_q_%0d q16=%0d q10=%0d exp q16=%0d q10=%0d", i, q_a, q_b, m16, m10);
      end
    end
    en_a = 1'b0; load_a = 1'b0; pre_a = 1'b0;
    en_b = 1'b0; load_b = 1'b0; pre_b = 1'b0;
  endtask

  initial begin
    clr_b = 1'b1; en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; pre_b = 1'b0; d_b = '0;
    load_c = 1'b0; pre_c = 1'b0; d_c = '0;
    test_reset();
    clr_b = 1'b0;
    tick();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_enable_direction();
    test_cascade();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
